// File: rtl/ascon_io_bridge_if.sv
// Bus bundle for ascon_io_bridge: narrow input beats, wide core words,
// core results and the narrow output beat stream.
interface ascon_io_bridge_if #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 2,
  parameter int WORD_W = 64,
  parameter int DEPTH  = 4
);
  localparam int NB_IN   = WORD_W / IN_W;
  localparam int BEATS_W = $clog2(NB_IN) + 1;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  // GPIO input side
  logic [IN_W-1:0]    in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;

  // Word stream towards the core
  logic [WORD_W-1:0]  word_data;
  logic               word_valid;
  logic               word_last;
  logic [BEATS_W-1:0] word_beats;
  logic               word_ready;

  // Result stream from the core
  logic [WORD_W-1:0]  res_data;
  logic               res_valid;
  logic               res_ready;

  // GPIO output side
  logic [OUT_W-1:0]   out_data;
  logic               out_valid;
  logic               out_last;
  logic               out_ready;
  logic [LVL_W-1:0]   fifo_level;

  // Bridge view
  modport slave (
    input  in_data, in_valid, in_last, word_ready, res_data, res_valid, out_ready,
    output in_ready, word_data, word_valid, word_last, word_beats,
           res_ready, out_data, out_valid, out_last, fifo_level
  );

  // Surrounding GPIO mapping / core view
  modport master (
    output in_data, in_valid, in_last, word_ready, res_data, res_valid, out_ready,
    input  in_ready, word_data, word_valid, word_last, word_beats,
           res_ready, out_data, out_valid, out_last, fifo_level
  );
endinterface

// File: rtl/ascon_io_bridge.sv
// Pin-limited I/O bridge for the Ascon core: deserialises IN_W-bit beats
// into left-aligned WORD_W-bit words, and buffers core results in a small
// FIFO before serialising them onto an OUT_W-bit bus with backpressure.
module ascon_io_bridge #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 2,
  parameter int WORD_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  ascon_io_bridge_if.slave bus
);
  localparam int NB_IN  = WORD_W / IN_W;
  localparam int NB_OUT = WORD_W / OUT_W;
  localparam int CNT_W  = $clog2(NB_IN) + 1;
  localparam int OCNT_W = (NB_OUT > 1) ? $clog2(NB_OUT) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  typedef enum logic { FILL,  HOLD  } in_state_e;
  typedef enum logic { EMPTY, SHIFT } out_state_e;

  // ---------------------------------------------------------------- input
  in_state_e         in_state_q, in_state_d;
  logic [WORD_W-1:0] word_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_q;

  logic              in_fire;
  logic              word_fire;
  logic              in_done;
  logic [CNT_W-1:0]  cnt_inc;
  logic [WORD_W-1:0] word_shift;
  logic [WORD_W-1:0] word_aligned;

  assign in_fire    = bus.in_valid && (in_state_q == FILL);
  assign word_fire  = (in_state_q == HOLD) && bus.word_ready;
  assign cnt_inc    = cnt_q + 1'b1;
  assign in_done    = (cnt_inc == CNT_W'(NB_IN)) || bus.in_last;
  assign word_shift = (word_q << IN_W) | WORD_W'(bus.in_data);
  // Shifting the short word up pushes out any residue of the previous word
  // and zero-fills the unused low beats in one step.
  assign word_aligned = word_shift << (IN_W * (NB_IN - int'(cnt_inc)));

  // Input FSM state register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_state_q <= FILL;
    else      in_state_q <= in_state_d;
  end

  // Input FSM next state: close the word on the last or NB_IN-th beat
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    in_state_d = in_state_q;
    unique case (in_state_q)
      FILL: if (in_fire && in_done) in_state_d = HOLD;
      HOLD: if (word_fire)          in_state_d = FILL;
    endcase
  end

  // Input word assembly, beat count and last flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else if (in_fire) begin
      word_q <= in_done ? word_aligned : word_shift;
      cnt_q  <= cnt_inc;
      last_q <= bus.in_last;
    end else if (word_fire) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end
  end

  // Input FSM outputs, all from registered state
  always_comb begin
    bus.in_ready   = (in_state_q == FILL);
    bus.word_valid = (in_state_q == HOLD);
    bus.word_data  = word_q;
    bus.word_last  = last_q;
    bus.word_beats = cnt_q;
  end

  // ---------------------------------------------------------- result FIFO
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              full, empty, push, pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = bus.res_valid && !full;

  // FIFO storage write
  // NOTE: storage is deliberately not reset; clearing the pointers and level
  // is what discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.res_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign bus.res_ready  = !full;
  assign bus.fifo_level = level_q;

  // ------------------------------------------------------- output shifter
  out_state_e        out_state_q, out_state_d;
  logic [WORD_W-1:0] sh_q;
  logic [OCNT_W-1:0] ocnt_q;
  logic              beat_fire, last_beat, load;

  assign beat_fire = (out_state_q == SHIFT) && bus.out_ready;
  assign last_beat = (out_state_q == SHIFT) && (ocnt_q == OCNT_W'(NB_OUT - 1));
  // Reloading on the final handshake keeps consecutive words bubble-free.
  assign load      = !empty && ((out_state_q == EMPTY) || (beat_fire && last_beat));
  assign pop       = load;

  // Output FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_state_q <= EMPTY;
    else      out_state_q <= out_state_d;
  end

  // Output FSM next state: idle once the last beat leaves with nothing queued
  always_comb begin
    out_state_d = out_state_q;
    unique case (out_state_q)
      EMPTY: if (load)                            out_state_d = SHIFT;
      SHIFT: if (beat_fire && last_beat && !load) out_state_d = EMPTY;
    endcase
  end

  // Shift register load from the FIFO and per-beat shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q   <= '0;
      ocnt_q <= '0;
    end else if (load) begin
      sh_q   <= mem[rd_ptr];
      ocnt_q <= '0;
    end else if (beat_fire) begin
      sh_q   <= sh_q << OUT_W;
      ocnt_q <= last_beat ? '0 : ocnt_q + 1'b1;
    end
  end

  // Output FSM outputs; a fully shifted word leaves zeros on out_data
  always_comb begin
    bus.out_valid = (out_state_q == SHIFT);
    bus.out_last  = last_beat;
    bus.out_data  = sh_q[WORD_W-1 -: OUT_W];
  end
endmodule
